// File: rtl/cascaded_alu_pkg.sv
// Shared types for the queued cascaded ALU: opcodes, FSM states and the op-queue entry.
package cascaded_alu_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int RESULT_WIDTH = 2*DATA_WIDTH;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_SUB = 3'b101,
        OP_MAX = 3'b110,
        OP_CLR = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC1,
        EXECM
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        op_t                   op;
        logic                  chain;
    } opq_entry_t;

endpackage

// File: rtl/cascaded_alu_opq.sv
// In-order op queue: synchronous FIFO with wrap-around pointers and an extra lap bit.
module cascaded_alu_opq
    import cascaded_alu_pkg::*;
#(
    parameter int  QDEPTH  = 4,
    parameter type entry_t = opq_entry_t
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  entry_t                    din,
    input  logic                      pop,
    output entry_t                    dout,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int AW = $clog2(QDEPTH);

    entry_t      mem [QDEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cascaded_alu_pipe.sv
// Queued cascaded ALU: ops enter a FIFO, a small FSM pops and executes them in order.
module cascaded_alu_pipe
    import cascaded_alu_pkg::*;
#(
    parameter int DATA_WIDTH   = cascaded_alu_pkg::DATA_WIDTH,
    parameter int RESULT_WIDTH = 2*DATA_WIDTH,
    parameter int MUL_LATENCY  = 3,
    parameter int QDEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_op,
    output logic                    ready,
    input  logic [DATA_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   B,
    input  logic [2:0]              op_sel,
    input  logic                    chain,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    end_op,
    output logic                    chain_trunc,
    output logic                    busy
);

    localparam int DW  = DATA_WIDTH;
    localparam int RW  = RESULT_WIDTH;
    localparam int QAW = $clog2(QDEPTH);
    localparam int CW  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        op_t           op;
        logic          chain;
    } entry_t;

    entry_t        push_entry;
    entry_t        head;
    entry_t        cur;
    logic          q_empty;
    logic          q_full;
    logic [QAW:0]  q_count;
    logic [QAW:0]  count_next;
    logic          push;
    logic          pop;
    logic          done;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [RW-1:0] a_x;
    logic [RW-1:0] b_x;
    logic [RW-1:0] alu_out;

    assign push_entry = '{a: A, b: B, op: op_t'(op_sel), chain: chain};
    assign push       = start_op && ready;
    assign done       = (state == EXEC1) || ((state == EXECM) && (cnt == '0));
    assign pop        = !q_empty && ((state == IDLE) || done);
    assign count_next = q_count + (QAW+1)'(push) - (QAW+1)'(pop);
    assign busy       = (state != IDLE) || !q_empty;

    cascaded_alu_opq #(
        .QDEPTH  (QDEPTH),
        .entry_t (entry_t)
    ) u_opq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    always_comb begin
        state_next = state;
        if (pop) begin
            case (head.op)
                OP_MUL:  state_next = EXECM;
                OP_NOP:  state_next = IDLE;
                default: state_next = EXEC1;
            endcase
        end else if (done) begin
            state_next = IDLE;
        end
    end

    // Chained A reads the result register at execute time, so it sees the op retired on the pop edge.
    always_comb begin
        a_x = cur.chain ? RW'(result[DW-1:0]) : RW'(cur.a);
        b_x = RW'(cur.b);
        case (cur.op)
            OP_ADD:  alu_out = a_x + b_x;
            OP_SUB:  alu_out = a_x - b_x;
            OP_AND:  alu_out = a_x & b_x;
            OP_XOR:  alu_out = a_x ^ b_x;
            OP_MAX:  alu_out = (a_x > b_x) ? a_x : b_x;
            OP_MUL:  alu_out = a_x * b_x;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cur         <= '0;
            result      <= '0;
            end_op      <= 1'b0;
            chain_trunc <= 1'b0;
            ready       <= 1'b0;
        end else begin
            state       <= state_next;
            ready       <= (count_next != (QAW+1)'(QDEPTH));
            end_op      <= done;
            chain_trunc <= done && cur.chain && (cur.op != OP_CLR) && (|result[RW-1:DW]);
            if (done) result <= alu_out;
            if (pop) begin
                cur <= head;
                if (head.op == OP_MUL) cnt <= CW'(MUL_LATENCY-1);
            end else if ((state == EXECM) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cascaded_alu_pipe.sv
// Directed bench for cascaded_alu_pipe with hand-computed results and latencies.
module tb_cascaded_alu_pipe;

    localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, AND = 3'b010, XOR = 3'b011,
                           MUL = 3'b100, SUB = 3'b101, MAX = 3'b110, CLR = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_op;
    logic        ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op_sel;
    logic        chain;
    logic [15:0] result;
    logic        end_op;
    logic        chain_trunc;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_not_ready = 0;

    logic [15:0] q_res[$];
    logic        q_tr[$];
    int          q_cyc[$];

    cascaded_alu_pipe #(
        .DATA_WIDTH   (8),
        .RESULT_WIDTH (16),
        .MUL_LATENCY  (3),
        .QDEPTH       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_op    (start_op),
        .ready       (ready),
        .A           (A),
        .B           (B),
        .op_sel      (op_sel),
        .chain       (chain),
        .result      (result),
        .end_op      (end_op),
        .chain_trunc (chain_trunc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (end_op) begin
            q_res.push_back(result);
            q_tr.push_back(chain_trunc);
            q_cyc.push_back(cyc);
        end
        if (!ready && !rst) n_not_ready <= n_not_ready + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at #1 after a rising edge; holds the op until it is accepted.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ch);
        int t = 0;
        start_op = 1'b1; op_sel = op; A = a; B = b; chain = ch;
        while (!ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!ready) chk("issue_timeout", 32'(ready), 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        start_op = 1'b0;
    endtask

    task automatic wait_ends(input int n);
        int t = 0;
        while (q_res.size() < n && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("end_op_count", 32'(q_res.size()), 32'(n));
    endtask

    int b;
    int nr0;
    logic [15:0] exp4 [6] = '{16'd2, 16'd12, 16'd30, 16'd56, 16'd90, 16'd132};

    initial begin
        rst = 1'b1; start_op = 1'b0; A = '0; B = '0; op_sel = NOP; chain = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_end_op", 32'(end_op), 32'd0);
        chk("rst_trunc", 32'(chain_trunc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(ready), 32'd1);

        // 1: ADD with carry out, 2-cycle latency, single-cycle pulse
        b = q_res.size();
        issue(ADD, 8'hFF, 8'h01, 1'b0);
        wait_ends(b + 1);
        chk("add_result", 32'(q_res[b]), 32'h0100);
        chk("add_latency", 32'(q_cyc[b] - acc_cyc), 32'd2);
        chk("add_pulse_width", 32'(end_op), 32'd0);

        // 2: MUL full product, 4-cycle latency
        b = q_res.size();
        issue(MUL, 8'hFF, 8'hFF, 1'b0);
        wait_ends(b + 1);
        chk("mul_result", 32'(q_res[b]), 32'hFE01);
        chk("mul_latency", 32'(q_cyc[b] - acc_cyc), 32'd4);

        // 3: chained sequence issued back-to-back
        b = q_res.size();
        issue(ADD, 8'd5, 8'd3, 1'b0);
        issue(MUL, 8'h00, 8'd4, 1'b1);
        issue(SUB, 8'h00, 8'd40, 1'b1);
        issue(ADD, 8'h00, 8'd1, 1'b1);
        wait_ends(b + 4);
        chk("chain_r0", 32'(q_res[b]), 32'd8);
        chk("chain_r1", 32'(q_res[b+1]), 32'd32);
        chk("chain_r2", 32'(q_res[b+2]), 32'hFFF8);
        chk("chain_r3", 32'(q_res[b+3]), 32'h00F9);
        chk("chain_t0", 32'(q_tr[b]), 32'd0);
        chk("chain_t1", 32'(q_tr[b+1]), 32'd0);
        chk("chain_t2", 32'(q_tr[b+2]), 32'd0);
        chk("chain_t3", 32'(q_tr[b+3]), 32'd1);

        // remaining single-cycle ops, back-to-back, including SUB wrap and MAX both ways
        b = q_res.size();
        issue(AND, 8'hF0, 8'h3C, 1'b0);
        issue(XOR, 8'hF0, 8'h3C, 1'b0);
        issue(MAX, 8'h12, 8'h34, 1'b0);
        issue(MAX, 8'h90, 8'h7F, 1'b0);
        issue(SUB, 8'h03, 8'h05, 1'b0);
        wait_ends(b + 5);
        chk("and_result", 32'(q_res[b]), 32'h0030);
        chk("xor_result", 32'(q_res[b+1]), 32'h00CC);
        chk("max_b_result", 32'(q_res[b+2]), 32'h0034);
        chk("max_a_result", 32'(q_res[b+3]), 32'h0090);
        chk("sub_wrap_result", 32'(q_res[b+4]), 32'hFFFE);
        chk("single_cycle_rate", 32'(q_cyc[b+4] - q_cyc[b]), 32'd4);

        // 4: six MULs issued continuously; queue must fill and stall
        b = q_res.size();
        nr0 = n_not_ready;
        for (int i = 0; i < 6; i++) issue(MUL, 8'(2*i+1), 8'(2*i+2), 1'b0);
        wait_ends(b + 6);
        chk("mul_burst_ready_low", 32'(n_not_ready > nr0), 32'd1);
        for (int i = 0; i < 6; i++) chk($sformatf("mul_burst_%0d", i), 32'(q_res[b+i]), 32'(exp4[i]));

        // 5: reset mid-MUL discards the op
        b = q_res.size();
        issue(MUL, 8'd3, 8'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midmul_rst_ready", 32'(ready), 32'd0);
        chk("midmul_rst_result", 32'(result), 32'd0);
        chk("midmul_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midmul_ready_after", 32'(ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("midmul_no_end_op", 32'(q_res.size()), 32'(b));

        // chained A is 0 right after reset
        b = q_res.size();
        issue(ADD, 8'h55, 8'd7, 1'b1);
        wait_ends(b + 1);
        chk("chain_after_rst", 32'(q_res[b]), 32'd7);
        chk("chain_after_rst_trunc", 32'(q_tr[b]), 32'd0);

        // 6: NOP is silent, CLR clears with a pulse
        b = q_res.size();
        issue(ADD, 8'd2, 8'd3, 1'b0);
        wait_ends(b + 1);
        chk("pre_nop_result", 32'(q_res[b]), 32'd5);
        b = q_res.size();
        issue(NOP, 8'hAA, 8'hBB, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("nop_no_end_op", 32'(q_res.size()), 32'(b));
        chk("nop_result_held", 32'(result), 32'd5);
        chk("nop_idle", 32'(busy), 32'd0);
        issue(CLR, 8'hAA, 8'hBB, 1'b1);
        wait_ends(b + 1);
        chk("clr_result", 32'(q_res[b]), 32'd0);
        chk("clr_trunc", 32'(q_tr[b]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
